// File: rtl/vg_row_fetch_if.sv
// DMA handshake and display read port of the VG75-class row-fetch engine.
// The engine connects through the slave modport; the DMA/display side uses the master modport.
interface vg_row_fetch_if #(
   parameter int DATA_W = 8,
   parameter int COL_W  = 7
);
   logic              drq;
   logic              dack;
   logic [DATA_W-1:0] idata;
   logic [COL_W-1:0]  rd_col;
   logic [DATA_W-1:0] rd_data;

   modport master (
      input  drq, rd_data,
      output dack, idata, rd_col
   );

   modport slave (
      output drq, rd_data,
      input  dack, idata, rd_col
   );
endinterface

// File: rtl/vg_row_fetch.sv
// DMA row-fetch engine: bursts one character row into a ping-pong buffer on each row_start
// while the display side reads the previously completed row from the other bank.
module vg_row_fetch #(
   parameter int MAX_COLS = 80,
   parameter int COL_W    = 7,
   parameter int DATA_W   = 8
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             ce,
   input  logic             enable,
   input  logic [COL_W-1:0] cfg_cols,
   input  logic [1:0]       cfg_burst_len,
   input  logic [2:0]       cfg_burst_gap,
   input  logic             frame_start,
   input  logic             row_start,
   input  logic             clr_status,
   output logic             eos,
   output logic             underrun,
   vg_row_fetch_if.slave    bus
);
   localparam int PTR_W = COL_W + 1;
   localparam logic [PTR_W-1:0] LAST_MAX = PTR_W'(MAX_COLS - 1);

   typedef enum logic [1:0] {IDLE, FETCH, GAP, DONE} state_t;

   state_t            state;
   logic              req;
   logic              dmae;
   logic              wbank;
   logic              dack_q;
   logic [PTR_W-1:0]  wptr;
   logic [PTR_W-1:0]  len [2];
   logic [2:0]        bcnt;
   logic [5:0]        gcnt;
   logic [DATA_W-1:0] mem [2**PTR_W];

   logic [PTR_W-1:0]  row_last;
   logic [2:0]        blen_m1;
   logic [5:0]        gap_val;
   logic              accept;
   logic              take;
   logic              is_ctrl;
   logic              wr_en;
   logic              wr_last;
   logic              rs_dmae;

   always_comb begin
      row_last = ({1'b0, cfg_cols} > LAST_MAX) ? LAST_MAX : {1'b0, cfg_cols};
      blen_m1  = 3'((4'b0001 << cfg_burst_len) - 4'b0001);
      gap_val  = (cfg_burst_gap == 3'd0) ? 6'd0 : ({cfg_burst_gap, 3'b000} - 6'd1);
      accept   = bus.dack & ~dack_q;
      // row_start and frame_start take priority over a coincident DMA byte
      take     = accept & (state == FETCH) & dmae & enable & ~row_start & ~frame_start;
      is_ctrl  = (bus.idata[7:4] == 4'hF) & bus.idata[0];
      wr_en    = take & ~is_ctrl;
      wr_last  = (wptr == row_last);
      rs_dmae  = frame_start ? enable : (dmae & enable);
   end

   assign bus.drq = req;

   always_ff @(posedge clk_sys) begin
      if (wr_en) mem[{wbank, wptr[COL_W-1:0]}] <= bus.idata;
   end

   // Columns at or beyond the stored row length read as blank
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) bus.rd_data <= '0;
      else if ({1'b0, bus.rd_col} < len[~wbank]) bus.rd_data <= mem[{~wbank, bus.rd_col}];
      else bus.rd_data <= '0;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         req      <= 1'b0;
         dmae     <= 1'b0;
         wbank    <= 1'b0;
         dack_q   <= 1'b0;
         wptr     <= '0;
         len[0]   <= '0;
         len[1]   <= '0;
         bcnt     <= '0;
         gcnt     <= '0;
         eos      <= 1'b0;
         underrun <= 1'b0;
      end else begin
         dack_q <= bus.dack;
         if (clr_status) begin
            underrun <= 1'b0;
            eos      <= 1'b0;
         end
         if (row_start && !frame_start && (state == FETCH || state == GAP) && dmae) begin
            // Row still incomplete: keep the display bank and stop fetching until next frame
            underrun <= 1'b1;
            dmae     <= 1'b0;
            req      <= 1'b0;
            state    <= IDLE;
         end else if (row_start) begin
            dmae       <= rs_dmae;
            wbank      <= ~wbank;
            wptr       <= '0;
            bcnt       <= '0;
            len[~wbank] <= '0;
            state      <= rs_dmae ? FETCH : IDLE;
            req        <= rs_dmae;
         end else if (frame_start) begin
            dmae  <= enable;
            wptr  <= '0;
            bcnt  <= '0;
            state <= IDLE;
            req   <= 1'b0;
         end else begin
            if (!enable) begin
               dmae <= 1'b0;
               req  <= 1'b0;
            end
            unique case (state)
               FETCH: begin
                  if (take) begin
                     if (is_ctrl) begin
                        len[wbank] <= wptr;
                        state      <= DONE;
                        req        <= 1'b0;
                        if (bus.idata[1]) begin
                           eos  <= 1'b1;
                           dmae <= 1'b0;
                        end
                     end else begin
                        wptr <= wptr + 1'b1;
                        if (wr_last) begin
                           len[wbank] <= row_last + 1'b1;
                           state      <= DONE;
                           req        <= 1'b0;
                        end else if (bcnt == blen_m1) begin
                           bcnt <= '0;
                           if (gap_val != 6'd0) begin
                              state <= GAP;
                              gcnt  <= gap_val;
                              req   <= 1'b0;
                           end
                        end else begin
                           bcnt <= bcnt + 1'b1;
                        end
                     end
                  end
               end
               GAP: begin
                  if (ce) begin
                     if (gcnt <= 6'd1) begin
                        state <= FETCH;
                        req   <= dmae & enable;
                     end else begin
                        gcnt <= gcnt - 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule
